// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported 32-bit data memory.
// Latency: req sampled at edge N, memory driven in cycle N+1, ack/rdata/err in cycle N+2.
// Backpressure: one transaction per 3 cycles; requests are ignored outside IDLE and must be held until ack.
module dmem_arbiter #(
  parameter int NUM_WORDS = 32,
  parameter int IDX_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_read_flag,
  output logic        mem_write_flag,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_val,
  input  logic [31:0] mem_read_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        gnt_port;
  logic        addr_ok;

  // Tie goes to the port that did not win last; otherwise whoever is asking.
  // Word-aligned and below NUM_WORDS*4 (NUM_WORDS is 2**IDX_W, so upper bits must be clear).
  always_comb begin
    gnt_port = (req0 && req1) ? ~last_grant_q : req1;
    addr_ok  = (addr_q[1:0] == 2'b00) && (addr_q[31:IDX_W+2] == '0);
  end

  // Transaction sequencing: latch the winner in IDLE, sample read data leaving ACCESS.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          port_d       = gnt_port;
          last_grant_d = gnt_port;
          we_d         = gnt_port ? we1    : we0;
          addr_d       = gnt_port ? addr1  : addr0;
          wdata_d      = gnt_port ? wdata1 : wdata0;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Writes and rejected accesses report zero read data.
        rdata_d = (addr_ok && !we_q) ? mem_read_out : 32'h0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched request registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Output decode: flags only in ACCESS with a legal address, ack/err only in RESP.
  always_comb begin
    mem_write_flag = (state_q == S_ACCESS) && addr_ok && we_q;
    mem_read_flag  = (state_q == S_ACCESS) && addr_ok && !we_q;
    mem_addr       = addr_q;
    mem_val        = wdata_q;
    ack0           = (state_q == S_RESP) && !port_q;
    ack1           = (state_q == S_RESP) && port_q;
    err            = (state_q == S_RESP) && !addr_ok;
    busy           = (state_q != S_IDLE);
    rdata          = rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural 32-word memory behind it.
// Latency: expectations are queued at issue time and checked when an ack appears.
// Backpressure: requesters hold req until ack, then drop it at the ack cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, busy, mem_read_flag, mem_write_flag;
  logic [31:0] rdata, mem_addr, mem_val, mem_read_out;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        init_done = 1'b0;
  logic [31:0] mem [32];

  dmem_arbiter #(.NUM_WORDS(32), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_addr(mem_addr), .mem_val(mem_val), .mem_read_out(mem_read_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: word i starts at 0x1000_0000+i, except word 1 = 0x1111_1111.
  assign mem_read_out = mem[mem_addr[6:2]];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 1) ? 32'h1111_1111 : 32'h1000_0000 + i;
    end else if (mem_write_flag) begin
      mem[mem_addr[6:2]] <= mem_val;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops the oldest expectation and compares it.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      chk("single_ack", {31'd0, ack0 && ack1}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_port", {31'd0, ack1}, {31'd0, e.port});
        chk("ack_err", {31'd0, err}, {31'd0, e.err});
        chk("ack_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic push(input int p, input logic e, input logic [31:0] r);
    exp_t x;
    x.port = p[0]; x.err = e; x.rdata = r;
    exp_q.push_back(x);
  endtask

  // Waits (bounded) for the given port's ack; returns cycles waited.
  task automatic wait_ack(input int p, input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((p == 0) ? ack0 : ack1) && n < lim);
    if (!((p == 0) ? ack0 : ack1)) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  // Single transaction from idle: checks ACCESS-cycle flags, latency and busy width.
  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic e, input logic [31:0] r);
    int n;
    push(p, e, r);
    drive(p, 1'b1, w, a, d);
    @(negedge clk);
    chk("access_busy", {31'd0, busy}, 32'd1);
    chk("access_wflag", {31'd0, mem_write_flag}, {31'd0, w && !e});
    chk("access_rflag", {31'd0, mem_read_flag}, {31'd0, !w && !e});
    if (!e) chk("access_addr", mem_addr, a);
    wait_ack(p, 6, n);
    chk("ack_latency", n, 32'd1);
    chk("resp_busy", {31'd0, busy}, 32'd1);
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("ack_width", {30'd0, ack1, ack0}, 32'd0);
  endtask

  initial begin
    int n, t0;
    int ord[4] = '{0, 1, 0, 1};

    // Reset state
    repeat (2) @(negedge clk);
    init_done = 1'b1;
    chk("rst_outs", {26'd0, ack0, ack1, err, busy, mem_read_flag, mem_write_flag}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mval", mem_val, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then read-back on port 0
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Port 1 misaligned read and out-of-range write
    issue(1, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0);
    issue(1, 1'b1, 32'h80, 32'hBAD0_BAD0, 1'b1, 32'h0);
    chk("oor_mem0", mem[0], 32'h1000_0000);

    // Both held over four transactions: strict alternation starting at port 0
    push(0, 1'b0, 32'hDEAD_BEEF); push(1, 1'b0, 32'h1000_0005);
    push(0, 1'b0, 32'hDEAD_BEEF); push(1, 1'b0, 32'h1000_0005);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(ord[k], 8, n);
      if (k > 0) chk("alt_gap", cyc - t0, 32'd3);
      t0 = cyc;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // req1 arrives while port 0 is in ACCESS
    push(0, 1'b0, 32'hDEAD_BEEF); push(1, 1'b0, 32'h1000_0006);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h18, 32'h0);
    wait_ack(0, 6, n);
    t0 = cyc;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_ack(1, 8, n);
    chk("late_gap", cyc - t0, 32'd3);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Reset in the middle of a write's ACCESS cycle
    drive(0, 1'b1, 1'b1, 32'h04, 32'hCAFE_F00D);
    @(negedge clk);
    chk("pre_rst_wflag", {31'd0, mem_write_flag}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wflag_drop", {30'd0, busy, mem_write_flag}, 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_noack", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_mem1", mem[1], 32'h1111_1111);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie after reset: port 0 wins first
    push(0, 1'b0, 32'h1111_1111); push(1, 1'b0, 32'h1000_0002);
    drive(0, 1'b1, 1'b0, 32'h04, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h08, 32'h0);
    wait_ack(0, 6, n);
    chk("tie_latency", n, 32'd2);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_ack(1, 8, n);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Boundary word indices 0 and 31
    issue(0, 1'b1, 32'h00, 32'hA5A5_A5A5, 1'b0, 32'h0);
    issue(0, 1'b1, 32'h7C, 32'h5A5A_5A5A, 1'b0, 32'h0);
    issue(0, 1'b0, 32'h00, 32'h0, 1'b0, 32'hA5A5_A5A5);
    issue(0, 1'b0, 32'h7C, 32'h0, 1'b0, 32'h5A5A_5A5A);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
